// File: rtl/fpga_cfg_pkg.sv
// ---------------------------------------------------------------------------
// fpga_cfg_pkg
// Shared sizes and state encoding for the fabric configuration loader.
//   CFG_W_DEF      : width of one configuration frame on the fabric port
//   NUM_FRAMES_DEF : number of frames, also width of the one-hot write strobe
//   cfg_state_t    : loader sequencing states
// ---------------------------------------------------------------------------
package fpga_cfg_pkg;

    localparam int CFG_W_DEF      = 224;
    localparam int NUM_FRAMES_DEF = 245;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        ARM,
        DONE
    } cfg_state_t;

    // Larger of two ints, used to size the shared wait timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cfg_wait_timer.sv
// ---------------------------------------------------------------------------
// cfg_wait_timer
// Loadable down-counter. o_done is high for the single cycle in which the
// count is 1, i.e. the cycle before the count reaches zero. A load on the
// same edge takes priority over the decrement.
// Ports:
//   clock   : clock, posedge
//   rst     : asynchronous active-low reset
//   i_load  : load i_value on the next edge
//   i_value : reload value (>=1 for a done pulse to occur)
//   o_done  : one-cycle terminal pulse
// ---------------------------------------------------------------------------
module cfg_wait_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/fpga_config_loader.sv
// ---------------------------------------------------------------------------
// fpga_config_loader
// Streams configuration frames into the fabric: each accepted frame is
// presented on configs_in with a one-hot configs_en strobe for one cycle.
// After the last frame and a settle window, ff_en rises; rdy follows after
// RDY_DELAY cycles. start in DONE reconfigures from frame 0.
// Ports:
//   clock, rst            : clock (posedge), async active-low reset
//   start                 : begin / restart a load (IDLE and DONE only)
//   in_data, in_valid     : frame stream input
//   in_ready              : frame accepted this cycle if in_valid (state-only)
//   configs_in, configs_en: registered frame and one-hot strobe to the fabric
//   ff_en, rdy            : fabric flip-flop enable, configured-and-running
//   busy                  : high in LOAD, SETTLE and ARM
// ---------------------------------------------------------------------------
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CFG_W         = CFG_W_DEF,
    parameter int NUM_FRAMES    = NUM_FRAMES_DEF,
    parameter int SETTLE_CYCLES = 10,
    parameter int RDY_DELAY     = 10
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CFG_W-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [CFG_W-1:0]      configs_in,
    output logic [NUM_FRAMES-1:0] configs_en,
    output logic                  ff_en,
    output logic                  rdy,
    output logic                  busy
);

    localparam int CNT_W   = $clog2(NUM_FRAMES + 1);
    localparam int TMR_MAX = max_int(SETTLE_CYCLES + 1, RDY_DELAY);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(NUM_FRAMES - 1);
    localparam logic [CNT_W-1:0]      FRM_CNT  = CNT_W'(NUM_FRAMES);
    localparam logic [NUM_FRAMES-1:0] EN_ONE   = NUM_FRAMES'(1);
    // The timer is loaded on the edge that accepts the last frame, so the
    // strobe cycle of that frame is added ahead of the SETTLE_CYCLES idle ones.
    localparam logic [TMR_W-1:0]      SETTLE_LD = TMR_W'(SETTLE_CYCLES + 1);
    localparam logic [TMR_W-1:0]      ARM_LD    = TMR_W'(RDY_DELAY);

    cfg_state_t             r_state, w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CFG_W-1:0]       r_cfg;
    logic [NUM_FRAMES-1:0]  r_en;
    logic                   r_ff_en;
    logic                   r_rdy;

    logic                   w_hs;
    logic                   w_last;
    logic                   w_restart;
    logic                   w_tmr_load;
    logic [TMR_W-1:0]       w_tmr_val;
    logic                   w_tmr_done;

    // in_ready depends on registered state only.
    assign in_ready  = (r_state == LOAD) && (r_cnt < FRM_CNT);
    assign w_hs      = in_ready && in_valid;
    assign w_last    = w_hs && (r_cnt == LAST_IDX);
    assign w_restart = start && ((r_state == IDLE) || (r_state == DONE));

    cfg_wait_timer #(
        .W (TMR_W)
    ) u_wait_timer (
        .clock   (clock),
        .rst     (rst),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_val),
        .o_done  (w_tmr_done)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            IDLE: begin
                if (start) w_next = LOAD;
            end
            LOAD: begin
                if (w_last) begin
                    w_next     = SETTLE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (w_tmr_done) begin
                    w_next     = ARM;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = ARM_LD;
                end
            end
            ARM: begin
                if (w_tmr_done) w_next = DONE;
            end
            DONE: begin
                if (start) w_next = LOAD;
            end
            default: w_next = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_cfg   <= '0;
            r_en    <= '0;
            r_ff_en <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            // Strobe lasts exactly one cycle per accepted frame.
            r_en <= '0;
            if (w_hs) begin
                r_cfg <= in_data;
                r_en  <= EN_ONE << r_cnt;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_restart) begin
                r_cnt   <= '0;
                r_ff_en <= 1'b0;
                r_rdy   <= 1'b0;
            end
            if ((r_state == SETTLE) && w_tmr_done) r_ff_en <= 1'b1;
            if ((r_state == ARM) && w_tmr_done)    r_rdy   <= 1'b1;
        end
    end

    assign configs_in = r_cfg;
    assign configs_en = r_en;
    assign ff_en      = r_ff_en;
    assign rdy        = r_rdy;
    assign busy       = (r_state == LOAD) || (r_state == SETTLE) || (r_state == ARM);

endmodule

// File: tb/tb_fpga_config_loader.sv
module tb_fpga_config_loader;

    localparam int CFG_W = 8;
    localparam int NF    = 4;
    localparam int SC    = 3;
    localparam int RD    = 2;

    logic              clock = 1'b0;
    logic              rst;
    logic              start;
    logic [CFG_W-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic [CFG_W-1:0]  configs_in;
    logic [NF-1:0]     configs_en;
    logic              ff_en;
    logic              rdy;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    logic [CFG_W-1:0] fr     [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [NF-1:0]    exp_en [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    fpga_config_loader #(
        .CFG_W         (CFG_W),
        .NUM_FRAMES    (NF),
        .SETTLE_CYCLES (SC),
        .RDY_DELAY     (RD)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .configs_in (configs_in),
        .configs_en (configs_en),
        .ff_en      (ff_en),
        .rdy        (rdy),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cfg"},  32'(configs_in), 32'h0);
        chk({tag, "_en"},   32'(configs_en), 32'h0);
        chk({tag, "_ff"},   32'(ff_en),      32'h0);
        chk({tag, "_rdy"},  32'(rdy),        32'h0);
        chk({tag, "_rdyi"}, 32'(in_ready),   32'h0);
        chk({tag, "_busy"}, 32'(busy),       32'h0);
    endtask

    // Drives the four frames; with gaps, in_valid drops for one cycle between frames.
    task automatic run_load(input bit gaps);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = fr[i];
            step;
            chk($sformatf("en_f%0d", i),  32'(configs_en), 32'(exp_en[i]));
            chk($sformatf("cfg_f%0d", i), 32'(configs_in), 32'(fr[i]));
            chk($sformatf("rdyi_f%0d", i), 32'(in_ready), (i < 3) ? 32'h1 : 32'h0);
            in_valid = 1'b0;
            in_data  = 8'h5A;
            if (gaps && i < 3) begin
                step;
                chk($sformatf("gap_en%0d", i),  32'(configs_en), 32'h0);
                chk($sformatf("gap_cfg%0d", i), 32'(configs_in), 32'(fr[i]));
            end
        end
    endtask

    // Called right after the last-frame edge L; checks L+1..L+6 while a
    // surplus frame is offered and, optionally, start is pulsed in SETTLE.
    task automatic tail(input bit pulse_start);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        start    = pulse_start;
        for (int k = 1; k <= 6; k++) begin
            step;
            start = 1'b0;
            chk($sformatf("t_en%0d", k),   32'(configs_en), 32'h0);
            chk($sformatf("t_cfg%0d", k),  32'(configs_in), 32'hD4);
            chk($sformatf("t_rdyi%0d", k), 32'(in_ready),   32'h0);
            chk($sformatf("t_ff%0d", k),   32'(ff_en),      (k >= 4) ? 32'h1 : 32'h0);
            chk($sformatf("t_rdy%0d", k),  32'(rdy),        (k >= 6) ? 32'h1 : 32'h0);
            chk($sformatf("t_busy%0d", k), 32'(busy),       (k < 6) ? 32'h1 : 32'h0);
        end
        in_valid = 1'b0;
        step;
        chk("done_hold_ff",  32'(ff_en), 32'h1);
        chk("done_hold_rdy", 32'(rdy),   32'h1);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            start    = 1'($urandom);
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            step;
            chk_all_zero($sformatf("rst%0d", i));
        end
        start    = 1'b0;
        in_valid = 1'b0;
        rst      = 1'b1;
        step;
        step;
        chk_all_zero("idle");

        // start with in_valid high: state change only, no frame accepted.
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        step;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("st_en",   32'(configs_en), 32'h0);
        chk("st_cfg",  32'(configs_in), 32'h0);
        chk("st_rdyi", 32'(in_ready),   32'h1);
        chk("st_busy", 32'(busy),       32'h1);

        // Back-to-back load, surplus frame and start pulse in SETTLE.
        run_load(1'b0);
        tail(1'b1);

        // Reconfigure from DONE with in_valid gaps.
        start = 1'b1;
        step;
        start = 1'b0;
        chk("rc_ff",   32'(ff_en),    32'h0);
        chk("rc_rdy",  32'(rdy),      32'h0);
        chk("rc_rdyi", 32'(in_ready), 32'h1);
        chk("rc_busy", 32'(busy),     32'h1);
        run_load(1'b1);
        tail(1'b0);

        // Reset in the middle of a load, right after frame 1's strobe appears.
        start = 1'b1;
        step;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = fr[0];
        step;
        in_data  = fr[1];
        step;
        chk("mid_en", 32'(configs_en), 32'h2);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("arst");
        in_valid = 1'b0;
        step;
        rst = 1'b1;
        step;
        chk_all_zero("post_rst");

        start = 1'b1;
        step;
        start = 1'b0;
        chk("rl_rdyi", 32'(in_ready), 32'h1);
        run_load(1'b0);
        tail(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpga_config_loader.md
# fpga_config_loader

Synthesizable configuration sequencer for the `fpga` fabric. It accepts configuration frames over a valid/ready stream and writes each frame into the fabric through `configs_in` plus a one-hot `configs_en` strobe. After the last frame and a settle interval, it raises `ff_en` and then `rdy`. It sits between a bitstream source (ROM, SPI reader or testbench driver) and the `fpga` instance, replacing any file-driven load loop.

## Interface
- `CFG_W`, 224, width of one configuration frame (`configs_in`).
- `NUM_FRAMES`, 245, number of frames and width of `configs_en`.
- `SETTLE_CYCLES`, 10, idle cycles after the last frame strobe before `ff_en` rises; must be ≥1.
- `RDY_DELAY`, 10, cycles from `ff_en` rising to `rdy` rising; must be ≥1.
- `clock` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin or restart a load; sampled only in IDLE and DONE.
- `in_data` in CFG_W: configuration frame.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a frame this cycle.
- `configs_in` out CFG_W: frame presented to the fabric.
- `configs_en` out NUM_FRAMES: one-hot write strobe, or all zero.
- `ff_en` out 1: enables the fabric flip-flops.
- `rdy` out 1: fabric configured and running.
- `busy` out 1: high in LOAD, SETTLE and ARM.

## Operation
- Reset (`rst`=0, asynchronous): state IDLE, frame counter 0, wait counter 0. All outputs are 0: `configs_in`, `configs_en`, `ff_en`, `rdy`, `in_ready`, `busy`.
- States:
  - IDLE: `start`=1 → LOAD, frame counter cleared.
  - LOAD: `in_ready`=1 while the counter is below NUM_FRAMES. Each handshake (`in_valid`&&`in_ready` at a posedge) on frame k registers `configs_in`←`in_data` and `configs_en`←1<<k, then increments the counter. The transition that accepts frame NUM_FRAMES-1 moves to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to ARM with `ff_en`←1.
  - ARM: count RDY_DELAY cycles, then go to DONE with `rdy`←1.
  - DONE: `ff_en`=1 and `rdy`=1 hold. `start`=1 → LOAD, with `ff_en` and `rdy` cleared on the same edge (reconfiguration).
- `configs_en` is nonzero for exactly one cycle per accepted frame; it is 0 in every other cycle, including `in_valid` gaps.
- `configs_in` holds the last written frame until the next handshake or reset.
- Frame counter width is $clog2(NUM_FRAMES+1). It never exceeds NUM_FRAMES and does not wrap.
- `in_valid` outside LOAD: `in_ready`=0 and data is ignored. The loader never accepts surplus frames.
- `start` in LOAD, SETTLE or ARM: ignored.
- `start` and `in_valid` high together in IDLE: only the state change happens; no frame is accepted that cycle.
- Reset mid-load: abort immediately. Partial fabric configuration is not retained; a new `start` reloads from frame 0.

## Timing
- `start` sampled at edge S → `in_ready`=1 and `busy`=1 from S+1.
- Frame k accepted at edge A → `configs_in`=frame k and `configs_en`=1<<k during cycle A..A+1. The fabric captures at edge A+1.
- Throughput is one frame per cycle with `in_valid` held high: full load completes in NUM_FRAMES cycles.
- Last frame accepted at edge L:
  - `in_ready`=0 from L.
  - `ff_en` rises at edge L+1+SETTLE_CYCLES.
  - `rdy` rises RDY_DELAY edges after `ff_en`.
  - `busy` falls with `rdy` rising.
- All outputs are registered; there is no combinational path from inputs to outputs except `in_ready` (state-decoded only, no input dependency).

## Structure
- Package `fpga_cfg_pkg`: default CFG_W and NUM_FRAMES constants, and the state enum `cfg_state_t` {IDLE, LOAD, SETTLE, ARM, DONE}.
- One sub-module, `cfg_wait_timer`: loadable down-counter with a done pulse, instantiated once and reloaded with SETTLE_CYCLES and then RDY_DELAY.
- Top-level ties `fpga_cfg_pkg` sizes to the `fpga` port widths.

## Test plan
Parameters: CFG_W=8, NUM_FRAMES=4, SETTLE_CYCLES=3, RDY_DELAY=2.
- Reset held low, random inputs → all outputs 0. Release `rst`, no `start` → outputs stay 0.
- `start` pulse, then frames 0xA1, 0xB2, 0xC3, 0xD4 back-to-back → `configs_en` reads 0001, 0010, 0100, 1000 in consecutive cycles with matching `configs_in`. `ff_en` rises 4 cycles after the last strobe cycle begins; `rdy` rises 2 cycles after `ff_en`.
- `in_valid` toggled 1,0,1,0 → a strobe appears only in cycles following a handshake; `configs_en`=0 in the gap cycles; the sequence is unchanged.
- A fifth frame offered after the fourth is accepted → `in_ready`=0 and no strobe; `start` pulsed in SETTLE → ignored and timing unchanged.
- `rst` asserted after 2 frames → outputs 0 asynchronously. A new `start` with 4 frames → strobes begin again at 0001.
- In DONE, `start` pulsed → `ff_en` and `rdy` drop next cycle, `in_ready`=1; reload completes identically.
